// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: active-high segment patterns
// in {g,f,e,d,c,b,a} order.
package seven_seg_scanner_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seven_seg_scanner_bcd_to_seg.sv
// Combinational BCD nybble to active-high segment pattern; non-decimal codes
// render as a dash so corrupt counter values are visible on the display.
module bcd_to_seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] nyb,
  output logic [6:0] pat
);

  // Digit lookup with dash fallback
  always_comb begin
    pat = SEG_DASH;
    case (nyb)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver: scans one digit per dwell period from a
// per-frame snapshot of the digit bus, with anti-ghosting guard and zero blanking.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_HZ         = 100_000_000,
  parameter int REFRESH_HZ     = 1000,
  parameter int GUARD          = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_DIGITS*4-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  input  logic                      blank_lz,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_start
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int GW  = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF_LVL = {7{SEG_INV}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF_LVL  = {NUM_DIGITS{AN_INV}};

  if (DIV < GUARD + 2 || NUM_DIGITS < 1) begin : g_bad_params
    $error("seven_seg_scanner: need DIV >= GUARD+2 and NUM_DIGITS >= 1");
  end

  logic [PW-1:0]           prescaler_r;
  logic [IW-1:0]           idx_r;
  logic [GW-1:0]           guard_r;
  logic [NUM_DIGITS*4-1:0] shadow_dig_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r;
  logic                    frame_start_r;
  logic [6:0]              seg_r;
  logic                    dp_r;
  logic [NUM_DIGITS-1:0]   an_r;

  logic                    tick_s;
  logic [3:0]              cur_nyb_s;
  logic [6:0]              pat_s;
  logic [6:0]              seg_hi_s;
  logic [NUM_DIGITS-1:0]   blank_s;
  logic [NUM_DIGITS-1:0]   an_on_s;

  assign tick_s    = (prescaler_r == PW'(DIV - 1));
  assign cur_nyb_s = shadow_dig_r[{idx_r, 2'b00} +: 4];

  bcd_to_seg u_dec (
    .nyb (cur_nyb_s),
    .pat (pat_s)
  );

  // Scan state: prescaler, digit index, guard countdown and frame snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_r   <= {PW{1'b0}};
      idx_r         <= IW'(NUM_DIGITS - 1);
      guard_r       <= {GW{1'b0}};
      shadow_dig_r  <= {(NUM_DIGITS*4){1'b0}};
      shadow_dp_r   <= {NUM_DIGITS{1'b0}};
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= 1'b0;
      if (enable) begin
        if (tick_s) begin
          prescaler_r <= {PW{1'b0}};
          guard_r     <= GW'(GUARD);
          if (idx_r == IW'(NUM_DIGITS - 1)) begin
            idx_r         <= {IW{1'b0}};
            shadow_dig_r  <= digits_in;
            shadow_dp_r   <= dp_mask;
            frame_start_r <= 1'b1;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end else begin
          prescaler_r <= prescaler_r + PW'(1);
          if (guard_r != {GW{1'b0}}) begin
            guard_r <= guard_r - GW'(1);
          end
        end
      end
    end
  end

  // Leading-zero mask: walk down from the MSD until a nonzero or dp-marked digit
  always_comb begin
    logic lead_v;
    lead_v  = 1'b1;
    blank_s = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (shadow_dig_r[i*4 +: 4] != 4'd0 || shadow_dp_r[i]) begin
        lead_v = 1'b0;
      end else begin
        lead_v = lead_v;
      end
      if (i != 0) begin
        blank_s[i] = lead_v & blank_lz;
      end else begin
        blank_s[i] = 1'b0;
      end
    end
  end

  // Anode select; the tick cycle is also dark so the segment change never overlaps a lit digit
  always_comb begin
    an_on_s = {NUM_DIGITS{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (guard_r == {GW{1'b0}} && !tick_s && idx_r == IW'(i)) begin
        an_on_s[i] = 1'b1;
      end else begin
        an_on_s[i] = 1'b0;
      end
    end
  end

  assign seg_hi_s = blank_s[idx_r] ? SEG_OFF : pat_s;

  // Output registers; polarity is applied only here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= SEG_OFF_LVL;
      dp_r  <= SEG_INV;
      an_r  <= AN_OFF_LVL;
    end else if (enable) begin
      seg_r <= seg_hi_s ^ SEG_OFF_LVL;
      dp_r  <= shadow_dp_r[idx_r] ^ SEG_INV;
      an_r  <= an_on_s ^ AN_OFF_LVL;
    end else begin
      seg_r <= SEG_OFF_LVL;
      dp_r  <= SEG_INV;
      an_r  <= AN_OFF_LVL;
    end
  end

  assign seg         = seg_r;
  assign dp          = dp_r;
  assign an          = an_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: cycle model driven by an enabled-cycle
// count, a vector table, hand sequences for startup/freeze/reset, and random stimulus.
module tb_seven_seg_scanner;

  localparam int NUM = 4;
  localparam int DIV = 10;
  localparam int GUARD = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b1;
  logic [15:0]     digits_in = 16'h1234;
  logic [3:0]      dp_mask = 4'h0;
  logic            blank_lz = 1'b0;
  logic [6:0]      seg;
  logic            dp;
  logic [3:0]      an;
  logic            frame_start;

  int ncmp = 0;
  int nfail = 0;
  bit chk_en = 1'b0;

  seven_seg_scanner #(
    .NUM_DIGITS(NUM), .CLK_HZ(40), .REFRESH_HZ(4), .GUARD(GUARD),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .digits_in(digits_in),
    .dp_mask(dp_mask), .blank_lz(blank_lz), .seg(seg), .dp(dp),
    .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h40;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: everything follows from n, the count of enabled cycles since reset
  int          n;
  logic [15:0] sh_dig;
  logic [3:0]  sh_dp;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_fs;

  always @(posedge clk or posedge rst) begin : model
    int p, d, cur, nn;
    logic [6:0] hi;
    bit blank, lit;
    if (rst) begin
      n <= 0; sh_dig <= 16'h0; sh_dp <= 4'h0;
      e_seg <= 7'h7F; e_dp <= 1'b1; e_an <= 4'hF; e_fs <= 1'b0;
    end else if (enable) begin
      p = n % DIV;
      d = n / DIV;
      cur = (d == 0) ? NUM - 1 : (d - 1) % NUM;
      blank = blank_lz && cur != 0 && (sh_dig >> (4 * cur)) == 16'h0 && (sh_dp >> cur) == 4'h0;
      hi = blank ? 7'h00 : seg_ref(sh_dig[4*cur +: 4]);
      lit = !(d >= 1 && p < GUARD) && p != DIV - 1;
      e_seg <= ~hi;
      e_dp  <= ~sh_dp[cur];
      e_an  <= lit ? ~(4'b0001 << cur) : 4'hF;
      nn = n + 1;
      n <= nn;
      if (nn % DIV == 0 && ((nn / DIV) - 1) % NUM == 0) begin
        sh_dig <= digits_in; sh_dp <= dp_mask; e_fs <= 1'b1;
      end else begin
        e_fs <= 1'b0;
      end
    end else begin
      e_seg <= 7'h7F; e_dp <= 1'b1; e_an <= 4'hF; e_fs <= 1'b0;
    end
  end

  // Continuous comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("seg", {25'h0, seg}, {25'h0, e_seg});
      check("dp", {31'h0, dp}, {31'h0, e_dp});
      check("an", {28'h0, an}, {28'h0, e_an});
      check("frame_start", {31'h0, frame_start}, {31'h0, e_fs});
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_fs(input string nm);
    int t = 0;
    do begin @(negedge clk); t++; end while (frame_start !== 1'b1 && t < 200);
    check({nm, "_fs_timeout"}, {31'h0, frame_start}, 32'h1);
  endtask

  task automatic wait_an(input string nm, input logic [3:0] v);
    int t = 0;
    do begin @(negedge clk); t++; end while (an !== v && t < 200);
    check({nm, "_an_timeout"}, {28'h0, an}, {28'h0, v});
  endtask

  // Startup timing after reset with digits 1234
  task automatic startup_seq(input string nm);
    logic [3:0] an_k [1:25];
    logic [6:0] seg_k [1:25];
    logic       fs_k [1:25];
    int lit0;
    do_reset();
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      an_k[k] = an; seg_k[k] = seg; fs_k[k] = frame_start;
    end
    lit0 = 0;
    for (int k = 1; k <= 25; k++) if (an_k[k] == 4'b1110) lit0++;
    check({nm, "_fs9"},  {31'h0, fs_k[9]},  32'h0);
    check({nm, "_fs10"}, {31'h0, fs_k[10]}, 32'h1);
    check({nm, "_fs11"}, {31'h0, fs_k[11]}, 32'h0);
    check({nm, "_an12"}, {28'h0, an_k[12]}, 32'hF);
    check({nm, "_an13"}, {28'h0, an_k[13]}, 32'hE);
    check({nm, "_seg13"}, {25'h0, seg_k[13]}, 32'h19);
    check({nm, "_lit0"}, lit0, 7);
    check({nm, "_an23"}, {28'h0, an_k[23]}, 32'hD);
    check({nm, "_seg23"}, {25'h0, seg_k[23]}, 32'h30);
  endtask

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dpm;
    logic        blz;
    int          pos;
    logic [6:0]  xseg;
    logic        xdp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int lit;
    vecs[0]  = '{16'h1234, 4'h0, 1'b0, 0, 7'h19, 1'b1};
    vecs[1]  = '{16'h1234, 4'h0, 1'b0, 3, 7'h79, 1'b1};
    vecs[2]  = '{16'h0050, 4'h0, 1'b1, 3, 7'h7F, 1'b1};
    vecs[3]  = '{16'h0050, 4'h0, 1'b1, 2, 7'h7F, 1'b1};
    vecs[4]  = '{16'h0050, 4'h0, 1'b1, 1, 7'h12, 1'b1};
    vecs[5]  = '{16'h0050, 4'h0, 1'b1, 0, 7'h40, 1'b1};
    vecs[6]  = '{16'h0050, 4'h4, 1'b1, 2, 7'h40, 1'b0};
    vecs[7]  = '{16'h0050, 4'h4, 1'b1, 3, 7'h7F, 1'b1};
    vecs[8]  = '{16'h00C0, 4'h0, 1'b0, 1, 7'h3F, 1'b1};
    vecs[9]  = '{16'h0000, 4'h0, 1'b1, 0, 7'h40, 1'b1};
    vecs[10] = '{16'h0000, 4'h0, 1'b0, 3, 7'h40, 1'b1};
    vecs[11] = '{16'h9876, 4'h1, 1'b0, 2, 7'h00, 1'b1};

    @(posedge clk);
    chk_en = 1'b1;
    startup_seq("start");

    foreach (vecs[i]) begin
      @(negedge clk);
      digits_in = vecs[i].dig; dp_mask = vecs[i].dpm; blank_lz = vecs[i].blz;
      wait_fs($sformatf("vec%0d", i));
      wait_an($sformatf("vec%0d", i), ~(4'b0001 << vecs[i].pos));
      check($sformatf("vec%0d_seg", i), {25'h0, seg}, {25'h0, vecs[i].xseg});
      check($sformatf("vec%0d_dp", i), {31'h0, dp}, {31'h0, vecs[i].xdp});
    end

    // Mid-frame bus change is invisible until the next snapshot
    @(negedge clk);
    digits_in = 16'h0009; dp_mask = 4'h0; blank_lz = 1'b0;
    wait_fs("mid");
    wait_an("mid_d0", 4'b1110);
    digits_in = 16'h0010;
    wait_an("mid_d1_old", 4'b1101);
    check("mid_old_seg", {25'h0, seg}, 32'h40);
    wait_fs("mid_new");
    wait_an("mid_d1_new", 4'b1101);
    check("mid_new_seg", {25'h0, seg}, 32'h79);

    // Freeze mid-dwell for 25 cycles; the dwell still totals its lit cycles
    digits_in = 16'h1234;
    wait_fs("frz");
    wait_an("frz_d1", 4'b1101);
    lit = 1;
    repeat (2) begin @(negedge clk); if (an == 4'b1101) lit++; end
    enable = 1'b0;
    @(negedge clk);
    check("frz_an_off", {28'h0, an}, 32'hF);
    check("frz_seg_off", {25'h0, seg}, 32'h7F);
    repeat (24) @(negedge clk);
    enable = 1'b1;
    for (int t = 0; t < 12; t++) begin @(negedge clk); if (an == 4'b1101) lit++; end
    check("frz_lit_total", lit, 7);

    // Async reset during the guard of digit 2, then an exact replay of startup
    wait_fs("rstg");
    wait_an("rstg_d1", 4'b1101);
    wait_an("rstg_gap", 4'b1111);
    #2 rst = 1'b1;
    #1;
    check("rstg_an", {28'h0, an}, 32'hF);
    check("rstg_seg", {25'h0, seg}, 32'h7F);
    check("rstg_dp", {31'h0, dp}, 32'h1);
    startup_seq("replay");

    // Random stimulus against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        for (int j = 0; j < 4; j++)
          digits_in[j*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 59) == 0) dp_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 29) == 0) enable = ~enable;
    end
    enable = 1'b1;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
